spi_reg_bridge: RTL and testbench



---
 rtl/spi_bridge_pkg.sv | 35 +++
 rtl/spi_bridge_wdog.sv | 36 +++
 rtl/spi_bridge_reg_bridge_top.sv | 140 ++++++++++++++
 tb/tb_spi_reg_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
// Frame field positions, status word layout and FSM state encoding.
package spi_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_e;

   // Received frame: {rw, addr[6:0], wdata[7:0]}
   localparam int RW_BIT   = 15;
   localparam int ADDR_MSB = 14;
   localparam int ADDR_LSB = 8;
   localparam int DATA_MSB = 7;

   // Transmit word: {err, ovr, 5'b0, busy, rdata[7:0]}
   localparam int ERR_BIT  = 15;
   localparam int OVR_BIT  = 14;
   localparam int BUSY_BIT = 8;

   function automatic logic [15:0] pack_status(input logic       err,
                                               input logic       ovr,
                                               input logic       busy,
                                               input logic [7:0] rdata);
      logic [15:0] w;
      w                    = '0;
      w[ERR_BIT]           = err;
      w[OVR_BIT]           = ovr;
      w[BUSY_BIT]          = busy;
      w[DATA_MSB:0]        = rdata;
      return w;
   endfunction

endpackage

// File: rtl/spi_bridge_wdog.sv
// Bus wait counter for the bridge: cleared while idle, counts cycles a
// transaction waits for ack and flags expiry when the count hits TIMEOUT.
module spi_bridge_wdog #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [3:0] count_q, count_d;

   assign expired = (count_q == 4'(TIMEOUT));

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (run && !expired) begin
         count_d = count_q + 4'd1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/spi_bridge_reg_bridge_top.sv
// SPI frame to register-bus bridge top: decodes received frames into bus
// transactions and builds the status word. Optional bus timeout: SPI_BRIDGE_TIMEOUT_EN.
module spi_reg_bridge
   import spi_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT     = 15,
   parameter logic [7:0]  RD_ERR_DATA = 8'hFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        frame_done,
   input  logic [15:0] frame_rx,
   output logic [15:0] frame_tx,
   output logic [6:0]  bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_we,
   output logic        bus_re,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_ack,
   output logic        busy,
   output logic        err,
   output logic        ovr,
   input  logic        err_clr
);

   state_e      state_q, state_d;
   logic [6:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        we_q, we_d, re_q, re_d, busy_q, busy_d;
   logic        err_q, err_d, ovr_q, ovr_d;
   logic [15:0] tx_q, tx_d;
   logic        in_xfer, accept, drop, timeout;

   assign in_xfer = (state_q != IDLE);
   assign accept  = frame_done && !in_xfer;
   assign drop    = frame_done && in_xfer;

`ifdef SPI_BRIDGE_TIMEOUT_EN
   logic expired;
   logic unused_ok;
   assign unused_ok = frame_start;

   spi_bridge_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!in_xfer),
      .run     (in_xfer && !bus_ack),
      .expired (expired)
   );

   // An ack in the expiry cycle still counts as success.
   assign timeout = in_xfer && expired && !bus_ack;
`else
   logic unused_ok;
   assign unused_ok = ^{frame_start, 32'(TIMEOUT), RD_ERR_DATA};
   assign timeout   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:        if (frame_done) state_d = frame_rx[RW_BIT] ? READ : WRITE;
         WRITE, READ: if (bus_ack || timeout) state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   // Datapath and status next values; outputs are derived from next state
   // so every output is a flop and frame_tx reflects an ack one cycle later.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (accept) begin
         addr_d  = frame_rx[ADDR_MSB:ADDR_LSB];
         wdata_d = frame_rx[DATA_MSB:0];
      end
      if (state_q == READ) begin
         if (bus_ack)      rdata_d = bus_rdata;
         else if (timeout) rdata_d = RD_ERR_DATA;
      end

      err_d = err_q;
      if (timeout)      err_d = 1'b1;
      else if (err_clr) err_d = 1'b0;

      ovr_d = ovr_q;
      if (drop)         ovr_d = 1'b1;
      else if (err_clr) ovr_d = 1'b0;

      we_d   = (state_d == WRITE);
      re_d   = (state_d == READ);
      busy_d = (state_d != IDLE);
      tx_d   = pack_status(err_d, ovr_d, busy_d, rdata_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         ovr_q   <= 1'b0;
         tx_q    <= '0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         re_q    <= re_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         ovr_q   <= ovr_d;
         tx_q    <= tx_d;
      end
   end

   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign bus_we    = we_q;
   assign bus_re    = re_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign ovr       = ovr_q;
   assign frame_tx  = tx_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed self-checking bench for spi_reg_bridge with a bus-transaction
// scoreboard; covers the SPI_BRIDGE_TIMEOUT_EN build when that macro is set.
module tb_spi_reg_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_start, frame_done, bus_ack, err_clr;
   logic [15:0] frame_rx;
   logic [15:0] frame_tx;
   logic [6:0]  bus_addr;
   logic [7:0]  bus_wdata, bus_rdata;
   logic        bus_we, bus_re, busy, err, ovr;

   int total = 0;
   int fails = 0;

   // Expected bus transaction: {we, re, addr, wdata}
   logic [17:0] exp_q[$];

   always #5 clk = ~clk;

   spi_reg_bridge dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .frame_rx    (frame_rx),
      .frame_tx    (frame_tx),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_we      (bus_we),
      .bus_re      (bus_re),
      .bus_rdata   (bus_rdata),
      .bus_ack     (bus_ack),
      .busy        (busy),
      .err         (err),
      .ovr         (ovr),
      .err_clr     (err_clr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one frame_done pulse and record the transaction it should cause.
   task automatic send_frame(input logic [15:0] f);
      frame_rx   = f;
      frame_done = 1'b1;
      exp_q.push_back({~f[15], f[15], f[14:8], f[7:0]});
      step();
      frame_done = 1'b0;
   endtask

   task automatic wait_strobe(input string tag, output int lat);
      logic [17:0] e;
      lat = 0;
      while (!(bus_we || bus_re) && lat < 20) begin
         step();
         lat++;
      end
      if (!(bus_we || bus_re)) begin
         total++;
         fails++;
         $error("FAIL %s: observed no strobe within 20 cycles, expected a strobe", tag);
      end else if (exp_q.size() == 0) begin
         total++;
         fails++;
         $error("FAIL %s: observed unexpected strobe, expected none", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, {14'd0, bus_we, bus_re, bus_addr, bus_wdata}, {14'd0, e});
      end
   endtask

   task automatic do_ack(input logic [7:0] rd);
      bus_rdata = rd;
      bus_ack   = 1'b1;
      step();
      bus_ack   = 1'b0;
      bus_rdata = 8'h00;
   endtask

   task automatic no_strobe(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         if (bus_we || bus_re) seen++;
         step();
      end
      check(tag, seen, 0);
   endtask

   initial begin
      int lat;
      int n;
      rst_n = 1'b0; frame_start = 1'b0; frame_done = 1'b0; frame_rx = '0;
      bus_ack = 1'b0; bus_rdata = '0; err_clr = 1'b0;
      repeat (3) step();
      check("reset_outputs", {bus_we, bus_re, busy, err, ovr, bus_addr, bus_wdata}, '0);
      check("reset_frame_tx", frame_tx, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Write: ack two cycles after strobe
      send_frame(16'h12A5);
      wait_strobe("write_strobe", lat);
      check("write_latency", lat, 0);
      check("write_busy", busy, 1'b1);
      step(); step();
      check("write_strobe_held", bus_we, 1'b1);
      do_ack(8'h00);
      check("write_done", {bus_we, busy, err, ovr}, 4'b0000);
      check("write_frame_tx", frame_tx, 16'h0000);

      // Read: data returned in frame_tx one cycle after ack
      send_frame(16'h9300);
      wait_strobe("read_strobe", lat);
      check("read_busy_tx", frame_tx, 16'h0100);
      do_ack(8'h5C);
      check("read_done", {bus_re, busy}, 2'b00);
      check("read_frame_tx", frame_tx, 16'h005C);

      // Overrun: second frame one cycle after the first is dropped
      send_frame(16'h2211);
      frame_rx   = 16'h3344;
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      wait_strobe("ovr_strobe", lat);
      check("ovr_set", ovr, 1'b1);
      do_ack(8'h00);
      check("ovr_frame_tx", frame_tx, 16'h405C);
      no_strobe("ovr_single_xfer", 6);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("ovr_cleared", ovr, 1'b0);
      check("ovr_clr_frame_tx", frame_tx, 16'h005C);

      // frame_done coincident with ack: transaction completes, frame dropped
      send_frame(16'h4A3C);
      wait_strobe("coinc_strobe", lat);
      frame_rx   = 16'h1111;
      frame_done = 1'b1;
      bus_ack    = 1'b1;
      step();
      frame_done = 1'b0;
      bus_ack    = 1'b0;
      check("coinc_done", {bus_we, busy, ovr}, 3'b001);
      no_strobe("coinc_dropped", 5);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("coinc_cleared", ovr, 1'b0);

`ifdef SPI_BRIDGE_TIMEOUT_EN
      // Read never acked: strobe drops 16 cycles after assertion
      send_frame(16'h8100);
      wait_strobe("to_strobe", lat);
      n = 0;
      while (bus_re && n < 40) begin
         step();
         n++;
      end
      check("to_cycles", n, 16);
      check("to_status", {err, busy}, 2'b10);
      check("to_frame_tx", frame_tx, 16'h80FF);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("to_err_clr", err, 1'b0);

      // Ack exactly at count 15 is a success
      send_frame(16'h0766);
      wait_strobe("to_edge_strobe", lat);
      repeat (15) step();
      check("to_edge_held", bus_we, 1'b1);
      do_ack(8'h00);
      check("to_edge_done", {bus_we, busy, err}, 3'b000);
      check("to_edge_frame_tx", frame_tx, 16'h00FF);
`else
      // Without the watchdog the bridge waits indefinitely for ack
      send_frame(16'h8100);
      wait_strobe("wait_strobe", lat);
      repeat (40) step();
      check("wait_held", {bus_re, busy, err}, 3'b110);
      do_ack(8'h77);
      check("wait_done", {bus_re, busy, err}, 3'b000);
      check("wait_frame_tx", frame_tx, 16'h0077);
`endif

      // Reset mid-read: strobe drops asynchronously
      send_frame(16'h9400);
      wait_strobe("rst_strobe", lat);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_re", bus_re, 1'b0);
      check("rst_outputs", {bus_we, busy, err, ovr, bus_addr, bus_wdata}, '0);
      check("rst_frame_tx", frame_tx, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      no_strobe("rst_abandoned", 4);

      send_frame(16'h5566);
      wait_strobe("post_rst_strobe", lat);
      do_ack(8'h00);
      check("post_rst_done", {bus_we, busy, err, ovr}, 4'b0000);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
